// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults and centred-coordinate helper
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COORD_W = 10;
  localparam int H_CENTRE = H_ACTIVE / 2;
  localparam int V_CENTRE = V_ACTIVE / 2;
  function automatic logic [COORD_W-1:0] centre(input logic [COORD_W-1:0] cnt, input int half);
    return cnt - half[COORD_W-1:0];
  endfunction
endpackage

// File: rtl/pix_delay_line.sv
// pix_delay_line: enable-gated shift register with a loadable reset value
module pix_delay_line #(
  parameter int W = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];
  always_comb begin
    sr_d[0] = en ? din : sr_q[0];
    for (int i = 1; i < DEPTH; i++) sr_d[i] = en ? sr_q[i-1] : sr_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) sr_q[i] <= rst_val;
    else sr_q <= sr_d;
  end
  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_centered_timing.sv
// vga_centered_timing: VGA sync plus centred coordinates, each pixel spanning two clk cycles
module vga_centered_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP = vga_pkg::H_FP,
  parameter int   H_SYNC = vga_pkg::H_SYNC,
  parameter int   H_BP = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP = vga_pkg::V_FP,
  parameter int   V_SYNC = vga_pkg::V_SYNC,
  parameter int   V_BP = vga_pkg::V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DLY = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               display_on_d,
  output logic               frame_tick,
  output logic [7:0]         frame_cnt
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(VT - 1);
  localparam logic [COORD_W-1:0] H_ACT = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  logic               phase_q, phase_d;
  logic [COORD_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               h_last, v_last;
  always_comb begin
    h_last = hcnt_q == H_LAST;
    v_last = vcnt_q == V_LAST;
    phase_d = ~phase_q;
    hcnt_d = phase_q ? (h_last ? '0 : hcnt_q + 1'b1) : hcnt_q;
    vcnt_d = (phase_q && h_last) ? (v_last ? '0 : vcnt_q + 1'b1) : vcnt_q;
    frame_tick = phase_q && h_last && v_last;
    frame_cnt_d = frame_cnt_q + {7'd0, frame_tick};
    hsync = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    display_on = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      phase_q <= phase_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign pix_en = phase_q;
  assign x_pos = centre(hcnt_q, H_ACTIVE / 2);
  assign y_pos = centre(vcnt_q, V_ACTIVE / 2);
  assign frame_cnt = frame_cnt_q;
  // Shifting only on pix_en makes the delay count in pixel periods, not clk cycles.
  pix_delay_line #(.W(3), .DEPTH(PIPE_DLY)) u_dly (
    .clk(clk),
    .rst(rst),
    .en(phase_q),
    .rst_val({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0}),
    .din({hsync, vsync, display_on}),
    .dout({hsync_d, vsync_d, display_on_d})
  );
endmodule
